// File: rtl/mux_rr_nx1_reg_if.sv
// Bus interface for mux_rr_nx1_reg.
// Carries the mode and select controls, the N input channels with their valid/ready
// handshakes, and the registered output channel with its valid/ready handshake.
//   slave  : the multiplexer side (consumes channels, produces the output item)
//   master : the environment side (drives channels and out_ready)
interface mux_rr_nx1_reg_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4
);
    localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1;

    logic                 rr_en;
    logic [SELW-1:0]      sel;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_chan;
    logic                 out_valid;
    logic                 out_ready;

    modport slave (
        input  rr_en,
        input  sel,
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_chan,
        output out_valid,
        input  out_ready
    );

    modport master (
        output rr_en,
        output sel,
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_chan,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/mux_rr_nx1_reg.sv
// N-input, WIDTH-bit registered multiplexer with valid/ready handshakes.
// Channel selection is either fixed (bus.sel) or round-robin starting at an internal pointer.
// One registered output stage; accepts a new item every cycle while out_ready is high.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mux_rr_nx1_reg_if.slave: rr_en, sel, in_data/in_valid/in_ready (per channel),
//          out_data/out_chan/out_valid/out_ready (registered output)
module mux_rr_nx1_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4
) (
    input logic             clk,
    input logic             rst_n,
    mux_rr_nx1_reg_if.slave bus
);
    localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1;

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;
    logic [SELW-1:0]      out_chan_q, out_chan_d;
    logic [SELW-1:0]      ptr_q, ptr_d;

    logic                 load;
    logic                 xfer;
    logic                 fx_vld;
    logic                 rr_vld;
    logic [SELW-1:0]      rr_off;
    logic [SELW:0]        rr_sum;
    logic [SELW-1:0]      rr_idx;
    logic [2*N-1:0]       req_rot;
    logic                 gnt_vld;
    logic [SELW-1:0]      gnt_idx;
    logic [WIDTH-1:0]     gnt_data;

    // Output register may be replaced whenever empty or being drained. Held at 0 during
    // reset so no channel sees a handshake while the block is in reset.
    assign load = rst_n && (!out_valid_q || bus.out_ready);

    // Fixed mode: out-of-range sel never matches any channel, so it yields no grant.
    always_comb begin
        fx_vld = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
                fx_vld = 1'b1;
            end
        end
    end

    // Round-robin: rotate requests so bit 0 is the pointer channel, take the lowest set
    // bit, then map the offset back to a channel index modulo N.
    always_comb begin
        req_rot = {bus.in_valid, bus.in_valid} >> ptr_q;
        rr_vld  = 1'b0;
        rr_off  = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                rr_vld = 1'b1;
                rr_off = SELW'(k);
            end
        end
        rr_sum = {1'b0, ptr_q} + {1'b0, rr_off};
        if (rr_sum >= (SELW+1)'(N)) begin
            rr_sum = rr_sum - (SELW+1)'(N);
        end
        rr_idx = rr_sum[SELW-1:0];
    end

    assign gnt_vld = bus.rr_en ? rr_vld : fx_vld;
    assign gnt_idx = bus.rr_en ? rr_idx : bus.sel;
    assign xfer    = load && gnt_vld;

    always_comb begin
        bus.in_ready = '0;
        gnt_data     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_idx == SELW'(i)) begin
                bus.in_ready[i] = xfer;
                gnt_data        = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = gnt_vld;
        end
        if (xfer) begin
            out_data_d = gnt_data;
            out_chan_d = gnt_idx;
            if (bus.rr_en) begin
                ptr_d = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
endmodule
